// File: rtl/mux_pkg.sv
// Shared constants for the 4-channel mux/demux family.
package mux_pkg;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef logic [NUM_CH-1:0] ch_vec_t;
    typedef logic [SEL_W-1:0]  sel_t;
endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: first set req bit at ptr, ptr+1, ptr+2, ptr+3 (mod NUM_CH).
module rr_pick
    import mux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              any
);
    // Walk the channels starting at ptr; the first hit wins and later hits are ignored.
    always_comb begin
        logic [SEL_W-1:0] idx;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = ptr + SEL_W'(k);
            if (!any && req[idx]) begin
                any     = 1'b1;
                gnt_idx = idx;
                gnt[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rr_mux4.sv
// Four-channel round-robin mux with a one-deep registered output.
module rr_mux4
    import mux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel,
    input  logic                     out_ready
);
    logic [SEL_W-1:0]  ptr;
    logic [NUM_CH-1:0] gnt;
    logic [SEL_W-1:0]  gnt_idx;
    logic              any;
    logic              load;
    logic              take;

    rr_pick u_pick (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    // Output register is free, or its word leaves this same cycle.
    assign load = !out_valid || out_ready;
    // A channel word is taken whenever the register can load and someone asks.
    assign take = load && any && !rst;

    // Accept strobe depends only on valids, pointer and output state, never on data.
    always_comb begin
        in_ready = '0;
        if (take) in_ready = gnt;
    end

    // All state: reset wins; otherwise load a granted word or drain to empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load) begin
            if (any) begin
                out_valid <= 1'b1;
                out_data  <= in_data[gnt_idx*DATA_W +: DATA_W];
                out_sel   <= gnt_idx;
                ptr       <= gnt_idx + 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rr_mux4.sv
// Directed bench for rr_mux4: reset, full rotation, stall, single channel, drain, reset mid-stall.
module tb_rr_mux4;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_ready;

    int checks   = 0;
    int failures = 0;

    rr_mux4 #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic [7:0] d);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".sel"},   32'(out_sel),   32'(s));
        chk({tag, ".data"},  32'(out_data),  32'(d));
    endtask

    initial begin
        logic [1:0] es;
        // Reset with every channel requesting.
        rst       = 1'b1;
        in_valid  = 4'b1111;
        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        out_ready = 1'b1;
        #1;
        chk("rst_ready_pre", 32'(in_ready), 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_ready", 32'(in_ready), 32'h0);
            chk_out("rst_out", 1'b0, 2'd0, 8'h00);
        end

        // Full rotation, one word per cycle: 8 words then 3 more, ending on channel 2.
        rst = 1'b0;
        #1;
        for (int i = 0; i < 11; i++) begin
            es = 2'(i % 4);
            chk("rot_ready", 32'(in_ready), 32'(4'b0001 << es));
            tick();
            chk_out("rot_out", 1'b1, es, 8'hA0 + 8'(es));
        end

        // Stall on out_sel=2: no accepts, output frozen.
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_ready", 32'(in_ready), 32'h0);
            tick();
            chk_out("stall_out", 1'b1, 2'd2, 8'hA2);
        end
        out_ready = 1'b1;
        #1;
        chk("unstall_ready", 32'(in_ready), 32'b1000);
        tick();
        chk_out("unstall_out", 1'b1, 2'd3, 8'hA3);

        // Only channel 1 requests: granted every time regardless of ptr.
        in_valid = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            in_data = {8'hA3, 8'hA2, 8'h11 * 8'(i + 1), 8'hA0};
            #1;
            chk("solo_ready", 32'(in_ready), 32'b0010);
            tick();
            chk_out("solo_out", 1'b1, 2'd1, 8'h11 * 8'(i + 1));
        end

        // Stream ends: out_valid falls one cycle later, data/sel kept.
        in_valid = 4'b0000;
        #1;
        chk("end_ready", 32'(in_ready), 32'h0);
        tick();
        chk_out("end_out", 1'b0, 2'd1, 8'h33);
        tick();
        chk_out("end_out2", 1'b0, 2'd1, 8'h33);

        // Load channel 2 (ptr becomes 3), stall, then reset mid-stall.
        in_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        in_valid = 4'b0100;
        tick();
        chk_out("pre_rst_out", 1'b1, 2'd2, 8'hA2);
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        tick();
        chk_out("pre_rst_stall", 1'b1, 2'd2, 8'hA2);
        rst       = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(in_ready), 32'h0);
        tick();
        chk_out("rst_mid_out", 1'b0, 2'd0, 8'h00);
        rst      = 1'b0;
        in_valid = 4'b0110;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'b0010);
        tick();
        chk_out("post_rst_out", 1'b1, 2'd1, 8'hA1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rr_mux4.md
RR_MUX4 -- requirements
Module: rr_mux4

Interface
REQ-001 SHALL have parameter: DATA_W, 8, width of each channel's data word.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: in_valid  input  4  per-channel request; bit i means channel i offers a word.
REQ-005 SHALL have port: in_data  input  4*DATA_W  channel i word at bits [i*DATA_W +: DATA_W].
REQ-006 SHALL have port: in_ready  output  4  per-channel accept strobe, at most one bit set.
REQ-007 SHALL have port: out_valid  output  1  output register holds a word.
REQ-008 SHALL have port: out_data  output  DATA_W  selected word.
REQ-009 SHALL have port: out_sel  output  2  binary index of the source channel of out_data.
REQ-010 SHALL have port: out_ready  input  1  downstream accepts the word when high with out_valid.

Function
REQ-011 SHALL define the transfer on channel i as in_valid[i] && in_ready[i] at a rising edge, and the output transfer as out_valid && out_ready.
REQ-012 SHALL define load = !out_valid || out_ready (the output register is free or is draining this cycle).
REQ-013 SHALL compute the grant combinationally: first set in_valid bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-014 SHALL drive in_ready as the one-hot grant when load is high and any in_valid is set, else 4'b0000.
REQ-015 SHALL NOT make in_ready depend on in_data.
REQ-016 SHALL, on a channel transfer, register out_data = granted word, out_sel = granted index, out_valid = 1 at the next edge (latency 1 cycle).
REQ-017 SHALL, on a cycle with load high and no in_valid set, clear out_valid at the next edge and leave out_data/out_sel unchanged.
REQ-018 SHALL hold out_valid, out_data and out_sel stable while out_valid && !out_ready.
REQ-019 SHALL sustain one word per cycle when out_ready is held high and requests are present (simultaneous drain and load).
REQ-020 SHALL update ptr to (granted index + 1) mod 4 on each channel transfer; ptr SHALL be unchanged otherwise.
REQ-021 SHALL wrap ptr from 3 to 0 without gaps.
REQ-022 SHALL, with all four channels requesting continuously and out_ready high, grant in order 0,1,2,3,0,...
REQ-023 SHALL, when a channel drops in_valid without being granted, drop no data and change no state.
REQ-024 SHALL NOT produce out_sel values outside 0..3; out_sel SHALL equal the channel index that demux decode of out_sel would select.

Reset
REQ-025 SHALL, when rst is high at a rising edge, set out_valid = 0, out_data = 0, out_sel = 2'b00, ptr = 0.
REQ-026 SHALL drive in_ready = 4'b0000 during any cycle in which rst is high.
REQ-027 SHALL discard a word held in the output register when rst is asserted mid-stall; no transfer is reported for it.
REQ-028 SHALL give rst priority over all simultaneous load/drain events.

Structure
REQ-029 SHALL place NUM_CH = 4 and SEL_W = 2 in a shared package mux_pkg, used by this block and by future demux-side blocks.
REQ-030 SHALL isolate the rotating priority search in one combinational sub-module rr_pick (inputs req[3:0], ptr[1:0]; outputs gnt[3:0], gnt_idx[1:0], any).
REQ-031 SHALL keep all state (ptr, out_valid, out_data, out_sel) in rr_mux4 in a single clocked process.

Verification
REQ-032 SHALL cover: rst high 2 cycles with in_valid=4'b1111 -> in_ready=0000, out_valid=0, out_sel=0, out_data=0.
REQ-033 SHALL cover: after reset, in_valid=1111, data ch i = 8'hA0+i, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3, out_data A0,A1,A2,A3,..., one word per cycle from cycle 1.
REQ-034 SHALL cover: out_valid=1 with out_sel=2, out_data=8'hA2, out_ready=0 for 3 cycles while in_valid=1111 -> in_ready=0000, outputs unchanged; on out_ready=1 next word from channel 3.
REQ-035 SHALL cover: only in_valid[1] set, 3 words -> each granted on channel 1 despite ptr=2 after first grant; out_sel=1 each time.
REQ-036 SHALL cover: input stream ends (in_valid=0000) with out_ready=1 -> out_valid falls 1 cycle after the last transfer, out_data keeps last value.
REQ-037 SHALL cover: rst asserted while stalled with out_valid=1 -> next cycle out_valid=0, ptr=0, first subsequent grant goes to lowest requesting channel.
